scan_chain_controller: RTL and testbench

Test-side initiator for the design's mux-scan chains. It drives `scan_en`/`scan_in` into a chain of `CHAIN_LEN` scan flops and samples the chain's `scan_out`. Each run loads a pattern, applies functional capture cycles, unloads the response and compares it with an expected vector. It sits between the DFT test-access logic and one scan chain, such as the 4-bit scan shift register.

---
 rtl/scan_ctrl_pkg.sv | 15 +
 rtl/scan_misr.sv | 42 ++++
 rtl/scan_chain_controller.sv | 170 +++++++++++++++++
 tb/tb_scan_chain_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller and its optional MISR.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } scan_ctrl_state_t;

  localparam logic [15:0] SCAN_MISR_POLY = 16'h1021;
  localparam logic [15:0] SCAN_MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/scan_misr.sv
// Galois MISR compacting the unloaded scan response; reseeded to all-ones by clr.
module scan_misr
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned MISR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              sample_en,
  input  logic              sample_bit,
  output logic [MISR_W-1:0] sig
);

  localparam logic [MISR_W-1:0] POLY = MISR_W'(SCAN_MISR_POLY);
  localparam logic [MISR_W-1:0] SEED = '1;

  logic [MISR_W-1:0] sig_q, sig_d;
  logic [MISR_W-1:0] shifted;

  always_comb begin
    shifted = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? POLY : '0);
    sig_d   = sig_q;
    // Reseed takes priority, so a coincident sample is dropped.
    if (clr) begin
      sig_d = SEED;
    end else if (sample_en) begin
      sig_d = {shifted[MISR_W-1:1], shifted[0] ^ sample_bit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/scan_chain_controller.sv
// Scan test initiator: load pattern, capture, unload and compare against expected.
// Optional response MISR enabled by defining SCAN_MISR_EN.
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 4,
  parameter int unsigned CAP_CYCLES = 1,
  parameter int unsigned MISR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] mismatch
`ifdef SCAN_MISR_EN
  ,
  input  logic                 misr_clr,
  output logic [MISR_W-1:0]    misr_sig
`endif
);

  localparam int unsigned MAX_LEN = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(CAP_CYCLES - 1);

  scan_ctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [CHAIN_LEN-1:0] resp_shift;
  logic                 unload_q, unload_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] mismatch_q, mismatch_d;

  // Outputs are registered from the current state, so the chain-facing view of
  // every phase trails the FSM by one cycle; unload_q marks the matching sample edges.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    resp_d     = resp_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;
    unload_d   = 1'b0;
    scan_en_d  = 1'b0;
    scan_in_d  = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_q != ST_IDLE);
    resp_shift = {resp_q[CHAIN_LEN-2:0], scan_out};

    if (unload_q) begin
      resp_d = resp_shift;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d      = pattern;
          exp_d      = expected;
          pass_d     = 1'b0;
          mismatch_d = '0;
          cnt_d      = LEN_CNT;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        scan_en_d = 1'b1;
        scan_in_d = pat_q[CHAIN_LEN-1];
        pat_d     = {pat_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == '0) begin
          cnt_d   = CAP_CNT;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == '0) begin
          cnt_d   = LEN_CNT;
          state_d = ST_UNLOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_UNLOAD: begin
        scan_en_d = 1'b1;
        unload_d  = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // The last response bit arrives on this same edge.
        done_d     = 1'b1;
        mismatch_d = resp_shift ^ exp_q;
        pass_d     = (resp_shift == exp_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      resp_q     <= '0;
      unload_q   <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      resp_q     <= resp_d;
      unload_q   <= unload_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign scan_en  = scan_en_q;
  assign scan_in  = scan_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

`ifdef SCAN_MISR_EN
  scan_misr #(
    .MISR_W(MISR_W)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .clr       (misr_clr),
    .sample_en (unload_q),
    .sample_bit(scan_out),
    .sig       (misr_sig)
  );
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller driving a 4-bit mux-scan register whose
// functional input shifts in a constant 1; MISR checks run when SCAN_MISR_EN is defined.
module tb_scan_chain_controller;

  localparam int N = 4;
  localparam int C = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         scan_en, scan_in, scan_out;
  logic         busy, done, pass;
  logic [N-1:0] mismatch;
  logic [N-1:0] chain = '0;
`ifdef SCAN_MISR_EN
  logic         misr_clr = 1'b0;
  logic [15:0]  misr_sig;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] exp;
    logic         want_pass;
    logic [N-1:0] want_mm;
  } vec_t;

  vec_t vecs[6];

  scan_chain_controller #(
    .CHAIN_LEN (N),
    .CAP_CYCLES(C),
    .MISR_W    (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .expected(expected),
    .scan_en (scan_en),
    .scan_in (scan_in),
    .scan_out(scan_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .mismatch(mismatch)
`ifdef SCAN_MISR_EN
    ,
    .misr_clr(misr_clr),
    .misr_sig(misr_sig)
`endif
  );

  always #5 clk = ~clk;

  // Attached chain: scan shift when scan_en, otherwise functional shift of data_in = 1.
  always @(posedge clk) chain <= scan_en ? {chain[N-2:0], scan_in} : {chain[N-2:0], 1'b1};
  assign scan_out = chain[N-1];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response = pattern after CAP_CYCLES functional shifts of a 1 into bit 0.
  function automatic logic [N-1:0] model_resp(input logic [N-1:0] p);
    logic [N-1:0] r;
    r = p;
    for (int i = 0; i < C; i++) r = {r[N-2:0], 1'b1};
    return r;
  endfunction

`ifdef SCAN_MISR_EN
  function automatic logic [15:0] model_misr(input logic [15:0] seed, input logic bits[$]);
    logic [15:0] s;
    logic fb;
    s = seed;
    foreach (bits[i]) begin
      fb = s[15];
      s  = {s[14:0], 1'b0};
      if (fb) s = s ^ 16'h1021;
      s[0] = s[0] ^ bits[i];
    end
    return s;
  endfunction
`endif

  task automatic run(input string nm, input logic [N-1:0] p, input logic [N-1:0] e,
                     input logic want_pass, input logic [N-1:0] want_mm);
    int lat;
    pattern = p;
    expected = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " cleared pass"}, pass, 0);
    check({nm, " cleared mm"}, mismatch, 0);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    check({nm, " done latency"}, lat, 10);
    check({nm, " pass"}, pass, want_pass);
    check({nm, " mismatch"}, mismatch, want_mm);
    tick();
    tick();
    check({nm, " done pulse"}, done, 0);
    check({nm, " pass held"}, pass, want_pass);
    check({nm, " mm held"}, mismatch, want_mm);
  endtask

  initial begin
    logic [1:0] seq[6];
    int busy_bad, done_cnt, done_at;
    logic [N-1:0] p, e, r;

    vecs[0] = '{4'b1011, 4'b0111, 1'b1, 4'b0000};
    vecs[1] = '{4'b1011, 4'b0110, 1'b0, 4'b0001};
    vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b0000};
    vecs[4] = '{4'b0101, 4'b0000, 1'b0, 4'b1011};
    vecs[5] = '{4'b1000, 4'b0001, 1'b1, 4'b0000};

    // Reset values
    tick();
    tick();
    check("rst scan_en", scan_en, 0);
    check("rst scan_in", scan_in, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst mismatch", mismatch, 0);
`ifdef SCAN_MISR_EN
    check("rst misr_sig", misr_sig, 16'hFFFF);
`endif
    rst = 1'b1;
    tick();

    // Bit order on the chain-facing pins: {scan_en, scan_in}
    seq = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10};
    pattern = 4'b1011;
    expected = 4'b0111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("bitorder edge t+%0d", k + 1), {scan_en, scan_in}, seq[k]);
    end
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check("bitorder done seen", done_cnt, 1);

    // Table-driven runs
    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), vecs[i].pat, vecs[i].exp, vecs[i].want_pass, vecs[i].want_mm);

    // Busy guard: start pulses in LOAD (edge t+3) and UNLOAD (edge t+8) are ignored
    pattern = 4'b1011;
    expected = 4'b0111;
    start = 1'b1;
    tick();
    pattern = 4'b0000;
    expected = 4'b1111;
    busy_bad = 0;
    done_cnt = 0;
    done_at = 0;
    for (int k = 1; k <= 16; k++) begin
      start = (k == 3 || k == 8);
      tick();
      if (busy !== ((k >= 1 && k <= 10) ? 1'b1 : 1'b0)) busy_bad++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
    end
    start = 1'b0;
    check("guard busy window", busy_bad, 0);
    check("guard done count", done_cnt, 1);
    check("guard done edge", done_at, 10);
    check("guard pass", pass, 1);

    // Reset in the middle of UNLOAD
    pattern = 4'b1011;
    expected = 4'b0111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    check("midrst scan_en", scan_en, 0);
    check("midrst scan_in", scan_in, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst pass", pass, 0);
    check("midrst mismatch", mismatch, 0);
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrst no done", done_cnt, 0);
    run("post-reset", 4'b0000, 4'b0001, 1'b1, 4'b0000);

    // Randomized runs against the reference model
    for (int i = 0; i < 20; i++) begin
      p = N'($urandom);
      r = model_resp(p);
      e = ($urandom_range(0, 1) == 1) ? r : N'($urandom);
      run($sformatf("rand%0d", i), p, e, (r == e), r ^ e);
      repeat ($urandom_range(0, 3)) tick();
    end

`ifdef SCAN_MISR_EN
    begin
      logic bits[$];
      misr_clr = 1'b1;
      tick();
      misr_clr = 1'b0;
      check("misr after clr", misr_sig, 16'hFFFF);
      for (int j = 0; j < 2; j++) begin
        r = model_resp(4'b1011);
        for (int b = N - 1; b >= 0; b--) bits.push_back(r[b]);
        run($sformatf("misr run%0d", j), 4'b1011, 4'b0111, 1'b1, 4'b0000);
      end
      check("misr signature", misr_sig, model_misr(16'hFFFF, bits));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
